// File: rtl/dac_feed.sv
// dac_feed: sample feeder for a first-order delta-sigma DAC modulator.
// Buffers RES-bit samples in a small FIFO (valid/ready in). Once per epoch of
// 2^LOG2_OSR enabled clocks it pops one sample and steps the modulator word.
// Optional feature macro: DAC_FEED_INTERP_EN
//   defined   -> linear ramp from the previous target to the new one
//   undefined -> zero-order hold (default build)
module dac_feed #(
  parameter int RES      = 8,
  parameter int LOG2_OSR = 6,
  parameter int FIFO_AW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RES-1:0]     s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               en,
  output logic [RES-1:0]     dac_in,
  output logic               underrun,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 1 << FIFO_AW;

  // FIFO storage and bookkeeping
  logic [RES-1:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [LOG2_OSR-1:0]  ph_q;
  logic                 underrun_q;

  logic                 full, empty, wr, epoch, pop;
  logic [RES-1:0]       head;

  assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // Readiness is judged on the pre-pop occupancy: a full FIFO refuses even
  // when an epoch pops in the same cycle.
  assign s_ready = !full && !rst;
  assign wr      = s_valid && s_ready;
  assign epoch   = en && (ph_q == '1);
  assign pop     = epoch && !empty;
  assign head    = mem_q[rd_ptr_q];

  assign level    = count_q;
  assign underrun = underrun_q;

  // Occupancy next-state from the write/pop combination
  always_comb begin
    // NOTE: default assignment first so every path drives count_d; without it
    // a missing branch would infer a latch.
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr) count_d = count_q - 1'b1;
  end

  // FIFO pointers, occupancy, epoch phase and sticky underrun flag
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ph_q       <= '0;
      underrun_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      // Phase wraps naturally from all-ones to zero on the epoch
      if (en)  ph_q <= ph_q + LOG2_OSR'(1);
      if (epoch && empty) underrun_q <= 1'b1;
    end
  end

  // Sample storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; emptiness is tracked by
    // count_q, and leaving the array unreset lets it map onto plain RAM.
    if (wr) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef DAC_FEED_INTERP_EN
  localparam int ACC_W = RES + LOG2_OSR;

  logic [RES-1:0]        b_q;
  logic signed [RES:0]   step_q;
  logic [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0] step_ext;

  // Sign-extend the per-cycle step to accumulator width
  assign step_ext = ACC_W'(step_q);

  // Ramp state: jump to the old target at the epoch, then add step each
  // enabled cycle so the ramp lands exactly on the new target one epoch later.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      b_q    <= '0;
      step_q <= '0;
    end else if (epoch) begin
      acc_q <= {b_q, {LOG2_OSR{1'b0}}};
      if (!empty) begin
        b_q    <= head;
        step_q <= {1'b0, head} - {1'b0, b_q};
      end else begin
        step_q <= '0;
      end
    end else if (en) begin
      acc_q <= acc_q + step_ext;
    end
  end

  assign dac_in = acc_q[ACC_W-1:LOG2_OSR];
`else
  logic [RES-1:0] dac_q;

  // Zero-order hold: load the popped sample, hold on underrun or when idle
  always_ff @(posedge clk) begin
    if (rst)      dac_q <= '0;
    else if (pop) dac_q <= head;
  end

  assign dac_in = dac_q;
`endif

endmodule
